// File: rtl/bs_tag_allocator_pkg.sv
// Shared sizing, types and debug view for the branch-stack tag allocator.
package bs_tag_allocator_pkg;

    localparam int unsigned B_MASK_WIDTH = 4;
    localparam int unsigned DISP_WIDTH   = 2;
    localparam int unsigned CNT_WIDTH    = $clog2(B_MASK_WIDTH + 1);

    typedef logic [B_MASK_WIDTH-1:0] b_mask_t;
    typedef logic [DISP_WIDTH-1:0]   disp_vec_t;

    typedef struct packed {
        b_mask_t                      live_mask;
        b_mask_t [B_MASK_WIDTH-1:0]   dep_mask;
    } bs_alloc_debug_t;

    function automatic logic [CNT_WIDTH-1:0] count_free(input b_mask_t live);
        return CNT_WIDTH'($countones(~live));
    endfunction

endpackage

// File: rtl/bs_tag_picker.sv
// Priority picker: returns the Picks lowest set bits of i_free as one-hot vectors, lowest first.
module bs_tag_picker #(
    parameter int unsigned Width = 4,
    parameter int unsigned Picks = 2
) (
    input  logic [Width-1:0]            i_free,
    output logic [Picks-1:0][Width-1:0] o_pick,
    output logic [Picks-1:0]            o_pick_valid
);

    logic [Width-1:0] w_remaining;

    always_comb begin
        w_remaining  = i_free;
        o_pick       = '0;
        o_pick_valid = '0;
        for (int p = 0; p < Picks; p++) begin
            // Isolate lowest set bit, then remove it for the next pick.
            o_pick[p]       = w_remaining & (~w_remaining + {{(Width-1){1'b0}}, 1'b1});
            o_pick_valid[p] = |w_remaining;
            w_remaining     = w_remaining & ~o_pick[p];
        end
    end

endmodule

// File: rtl/bs_tag_allocator.sv
// Branch-stack tag allocator: in-order dispatch grants, one-hot tag allocation,
// dependency masks, and tag release on correct resolve or mispredict squash.
module bs_tag_allocator
    import bs_tag_allocator_pkg::*;
(
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic [DISP_WIDTH-1:0]                i_disp_valid,
    input  logic [DISP_WIDTH-1:0]                i_disp_is_branch,
    input  logic                                 i_resolve_valid,
    input  logic [B_MASK_WIDTH-1:0]              i_resolve_bmm,
    input  logic                                 i_resolve_mispred,
    output logic [DISP_WIDTH-1:0]                o_disp_grant,
    output logic [DISP_WIDTH*B_MASK_WIDTH-1:0]   o_disp_tag,
    output logic [DISP_WIDTH*B_MASK_WIDTH-1:0]   o_disp_b_mask,
    output logic [B_MASK_WIDTH-1:0]              o_next_b_mask,
    output logic [CNT_WIDTH-1:0]                 o_free_count,
    output logic                                 o_full
);

    b_mask_t                    r_live_mask;
    b_mask_t [B_MASK_WIDTH-1:0] r_dep_mask;
    logic [CNT_WIDTH-1:0]       r_free_count;
    logic                       r_full;

    logic                                 w_hit;
    logic                                 w_correct;
    logic                                 w_mispred;
    b_mask_t                              w_squash_set;
    b_mask_t                              w_cleared;
    b_mask_t                              w_live_kept;
    logic [DISP_WIDTH-1:0][B_MASK_WIDTH-1:0] w_pick;
    logic [DISP_WIDTH-1:0]                w_pick_valid;
    disp_vec_t                            w_grant;
    logic [DISP_WIDTH-1:0][B_MASK_WIDTH-1:0] w_tag;
    logic [DISP_WIDTH-1:0][B_MASK_WIDTH-1:0] w_b_mask;
    b_mask_t                              w_new_tags;
    logic                                 w_tag_conflict;
    b_mask_t                              w_live_d;
    b_mask_t [B_MASK_WIDTH-1:0]           w_dep_d;

    // A resolve naming a tag that is not live is ignored entirely.
    assign w_hit     = i_resolve_valid & (|(i_resolve_bmm & r_live_mask));
    assign w_correct = w_hit & ~i_resolve_mispred;
    assign w_mispred = w_hit & i_resolve_mispred;

    always_comb begin
        w_squash_set = i_resolve_bmm;
        for (int t = 0; t < B_MASK_WIDTH; t++) begin
            if (|(r_dep_mask[t] & i_resolve_bmm)) w_squash_set[t] = 1'b1;
        end
        w_squash_set = w_squash_set & r_live_mask;
    end

    assign w_cleared   = w_correct ? i_resolve_bmm : (w_mispred ? w_squash_set : '0);
    assign w_live_kept = r_live_mask & ~w_cleared;

    // Picks come from the registered live mask so freed tags wait a cycle.
    bs_tag_picker #(
        .Width (B_MASK_WIDTH),
        .Picks (DISP_WIDTH)
    ) u_picker (
        .i_free       (~r_live_mask),
        .o_pick       (w_pick),
        .o_pick_valid (w_pick_valid)
    );

    always_comb begin
        int unsigned v_used;
        logic        v_blocked;
        b_mask_t     v_acc;
        v_used         = 0;
        v_blocked      = 1'b0;
        v_acc          = '0;
        w_grant        = '0;
        w_tag          = '0;
        w_b_mask       = '0;
        w_tag_conflict = 1'b0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            w_b_mask[i] = w_live_kept | v_acc;
            if (i_disp_valid[i]) begin
                if (!v_blocked && !w_mispred) begin
                    if (i_disp_is_branch[i]) begin
                        for (int k = 0; k < DISP_WIDTH; k++) begin
                            if (k == v_used && w_pick_valid[k]) begin
                                w_tag[i]   = w_pick[k];
                                w_grant[i] = 1'b1;
                            end
                        end
                        if (w_grant[i]) v_used = v_used + 1;
                    end else begin
                        w_grant[i] = 1'b1;
                    end
                end
                if (!w_grant[i]) v_blocked = 1'b1;
                w_tag_conflict = w_tag_conflict | (|(v_acc & w_tag[i]))
                                 | (|(r_live_mask & w_tag[i]));
                v_acc = v_acc | w_tag[i];
            end
        end
        w_new_tags = v_acc;
    end

    assign w_live_d = w_live_kept | w_new_tags;

    always_comb begin
        for (int t = 0; t < B_MASK_WIDTH; t++) begin
            w_dep_d[t] = w_cleared[t] ? '0 : (r_dep_mask[t] & ~w_cleared);
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (w_grant[i] && w_tag[i][t]) w_dep_d[t] = w_b_mask[i];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_live_mask  <= '0;
            r_dep_mask   <= '0;
            r_free_count <= CNT_WIDTH'(B_MASK_WIDTH);
            r_full       <= 1'b0;
        end else begin
            r_live_mask  <= w_live_d;
            r_dep_mask   <= w_dep_d;
            r_free_count <= count_free(w_live_d);
            r_full       <= &w_live_d;
        end
    end

    assign o_disp_grant  = i_reset ? w_grant  : '0;
    assign o_disp_tag    = i_reset ? w_tag    : '0;
    assign o_disp_b_mask = i_reset ? w_b_mask : '0;
    assign o_next_b_mask = i_reset ? w_live_d : '0;
    assign o_free_count  = r_free_count;
    assign o_full        = r_full;

`ifdef DEBUG
    bs_alloc_debug_t w_debug;
    assign w_debug = '{live_mask: r_live_mask, dep_mask: r_dep_mask};
`endif

    a_bmm_onehot0: assert property (@(posedge i_clock) disable iff (!i_reset)
        $onehot0(i_resolve_bmm));
    a_tag_exclusive: assert property (@(posedge i_clock) disable iff (!i_reset)
        !w_tag_conflict);

endmodule
